regbank_mp: RTL and testbench
=============================

// Module: regbank_mp
// PURPOSE
//  Parametrised multi-port register bank for the processor datapath; next generation of the 4-read bank.
//  Provides NUM_RD registered read ports, one writeback port and a dedicated PC register with load/hold.
//  Adds a busy-bit scoreboard that flags read-after-write hazards to the decode/stall logic.
//  Sits between decode (addresses, issue) and execute (operands), with writeback returning from the pipeline end.
// PARAMETERS
//  DATA_W    32            register and PC width
//  ADDR_W    4             register address width; NUM_REGS = 2**ADDR_W
//  NUM_RD    4             number of read ports (store-data, RS, RX, RK in the base ISA)
//  PC_RESET  32'h0000_0000 PC value after reset
// PORTS
//  clk         in   1                clock, rising edge
//  rst_n       in   1                synchronous reset, active low
//  rd_addr     in   NUM_RD*ADDR_W    read addresses, port i at [i*ADDR_W +: ADDR_W]
//  re          in   1                read enable, all ports
//  rd_data     out  NUM_RD*DATA_W    registered read data, port i at [i*DATA_W +: DATA_W]
//  we          in   1                writeback enable
//  wr_addr     in   ADDR_W           writeback address
//  wr_data     in   DATA_W           writeback value
//  issue_vld   in   1                instruction issued that will write issue_addr
//  issue_addr  in   ADDR_W           destination of the issued instruction
//  busy        out  NUM_REGS         scoreboard, bit r = write to r in flight
//  hazard      out  NUM_RD           combinational: re & busy[rd_addr[i]]
//  pc_we       in   1                load PC
//  pc_in       in   DATA_W           next PC value
//  pc_out      out  DATA_W           current PC
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): all registers 0, rd_data 0, busy 0, pc_out PC_RESET. Reset wins over every other input.
//  - Write: we=1 -> regs[wr_addr] <= wr_data at the edge; visible to reads issued the following cycle.
//  - Read: re=1 -> rd_data[i] <= regs[rd_addr[i]] at the edge (latency 1); re=0 -> rd_data holds its value.
//  - Same address on several read ports: each port returns the same value; no arbitration.
//  - Read/write collision (re & we, rd_addr[i]==wr_addr, same cycle): governed by REGBANK_BYPASS_EN (below).
//  - PC: pc_we=1 -> pc_out <= pc_in; else hold. PC is independent of the register array; there is no auto-increment.
//  - Scoreboard: issue_vld sets busy[issue_addr]; we clears busy[wr_addr].
//    Same cycle, same address: set wins (a new producer is in flight). Different addresses: both apply.
//    we to an address that is not busy: the write proceeds and busy stays 0.
//  - hazard[i] is computed from the current (pre-edge) busy vector; it is not forwarded from same-cycle issue or we.
//  - All arithmetic is index-only; addresses wrap naturally over NUM_REGS with no out-of-range case.
// CONFIGURATION
//  REGBANK_BYPASS_EN defined: a read colliding with a same-cycle write returns wr_data (write-first),
//    and hazard[i] is masked when we & wr_addr==rd_addr[i] and the scoreboard is not being re-set.
//  Not defined: the colliding read returns the old register value (read-first); hazard is unmasked.
// STRUCTURE
//  regbank_pkg: DATA_W/ADDR_W defaults, typedef logic [ADDR_W-1:0] reg_addr_t, typedef logic [DATA_W-1:0] word_t, PC_RESET default.
//  Sub-module regbank_scoreboard: busy vector (set/clear priority) plus hazard lookup; the array, read ports and PC stay in regbank_mp.
// TESTING
//  1 Reset: rst_n=0 one edge -> rd_data=0, busy=0, pc_out=PC_RESET; the next re=1 to any address reads 0.
//  2 Write r5=32'hDEAD_BEEF, then re with port0..3 addr 5,5,0,15 -> next cycle DEAD_BEEF, DEAD_BEEF, 0, 0.
//  3 Same cycle we r3=32'h1234 and re port1=r3 -> BYPASS_EN: rd_data[1]=1234; otherwise old value 0.
//  4 issue_vld r7 -> busy[7]=1, re port2=r7 gives hazard[2]=1; we r7 the next cycle -> busy[7]=0, hazard clears.
//  5 issue_vld r9 and we r9 in the same cycle -> busy[9] stays 1; issue r1 with we r2 (r2 busy) -> busy[1]=1, busy[2]=0.
//  6 pc_we=1 pc_in=32'h40 -> pc_out=40; pc_we=0 for 3 cycles -> holds 40; rst_n=0 mid-sequence -> PC_RESET, busy cleared.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared defaults, word/address types and sizing helper for the multi-port register bank.
package regbank_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int NUM_RD_DEF = 4;
    localparam logic [DATA_W_DEF-1:0] PC_RESET_DEF = 32'h0000_0000;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

    function automatic int numRegs(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/regbank_mp_if.sv
// Decode/execute/writeback bundle of the register bank; master = pipeline side, slave = bank.
interface regbank_mp_if
    import regbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
);
    localparam int NUM_REGS = numRegs(ADDR_W);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic                     re;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     we;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     issue_vld;
    logic [ADDR_W-1:0]        issue_addr;
    logic [NUM_REGS-1:0]      busy;
    logic [NUM_RD-1:0]        hazard;
    logic                     pc_we;
    logic [DATA_W-1:0]        pc_in;
    logic [DATA_W-1:0]        pc_out;

    modport master (
        output rd_addr, re, we, wr_addr, wr_data, issue_vld, issue_addr, pc_we, pc_in,
        input  rd_data, busy, hazard, pc_out
    );

    modport slave (
        input  rd_addr, re, we, wr_addr, wr_data, issue_vld, issue_addr, pc_we, pc_in,
        output rd_data, busy, hazard, pc_out
    );

endinterface

// File: rtl/regbank_scoreboard.sv
// Busy-bit scoreboard with per-read-port hazard lookup.
// REGBANK_BYPASS_EN: mask hazards that the same-cycle writeback resolves.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_issueVld,
    input  logic [ADDR_W-1:0]        i_issueAddr,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_wrAddr,
    input  logic                     i_re,
    input  logic [NUM_RD*ADDR_W-1:0] i_rdAddr,
    output logic [(1<<ADDR_W)-1:0]   o_busy,
    output logic [NUM_RD-1:0]        o_hazard
);
    localparam int NUM_REGS = numRegs(ADDR_W);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_setMask;
    logic [NUM_REGS-1:0] w_clrMask;

    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        if (i_issueVld) w_setMask[i_issueAddr] = 1'b1;
        if (i_we)       w_clrMask[i_wrAddr]    = 1'b1;
    end

    // Set is applied after clear so a new producer wins over a retiring one.
    always_ff @(posedge clk) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= (r_busy & ~w_clrMask) | w_setMask;
    end

    always_comb begin
        o_hazard = '0;
        for (int i = 0; i < NUM_RD; i++) begin
`ifdef REGBANK_BYPASS_EN
            o_hazard[i] = i_re & r_busy[i_rdAddr[i*ADDR_W +: ADDR_W]]
                        & ~(w_clrMask[i_rdAddr[i*ADDR_W +: ADDR_W]]
                            & ~w_setMask[i_rdAddr[i*ADDR_W +: ADDR_W]]);
`else
            o_hazard[i] = i_re & r_busy[i_rdAddr[i*ADDR_W +: ADDR_W]];
`endif
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regbank_mp.sv
// Multi-port register bank: NUM_RD registered read ports, one writeback port, PC register, scoreboard.
// REGBANK_BYPASS_EN: write-first forwarding on read/write collisions (read-first otherwise).
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                NUM_RD   = NUM_RD_DEF,
    parameter logic [DATA_W-1:0] PC_RESET = PC_RESET_DEF
)
(
    input  logic         clk,
    input  logic         rst_n,
    regbank_mp_if.slave  bus
);
    localparam int NUM_REGS = numRegs(ADDR_W);

    logic [DATA_W-1:0]        r_regFile [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0] r_rdData;
    logic [NUM_RD*DATA_W-1:0] w_rdNext;
    logic [DATA_W-1:0]        r_pc;

    always_comb begin
        w_rdNext = r_rdData;
        if (bus.re) begin
            for (int i = 0; i < NUM_RD; i++) begin
                w_rdNext[i*DATA_W +: DATA_W] = r_regFile[bus.rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGBANK_BYPASS_EN
                if (bus.we && (bus.wr_addr == bus.rd_addr[i*ADDR_W +: ADDR_W]))
                    w_rdNext[i*DATA_W +: DATA_W] = bus.wr_data;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) r_regFile[r] <= '0;
            r_rdData <= '0;
            r_pc     <= PC_RESET;
        end else begin
            if (bus.we)    r_regFile[bus.wr_addr] <= bus.wr_data;
            r_rdData <= w_rdNext;
            if (bus.pc_we) r_pc <= bus.pc_in;
        end
    end

    assign bus.rd_data = r_rdData;
    assign bus.pc_out  = r_pc;

    regbank_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_issueVld  (bus.issue_vld),
        .i_issueAddr (bus.issue_addr),
        .i_we        (bus.we),
        .i_wrAddr    (bus.wr_addr),
        .i_re        (bus.re),
        .i_rdAddr    (bus.rd_addr),
        .o_busy      (bus.busy),
        .o_hazard    (bus.hazard)
    );

endmodule

// File: tb/tb_regbank_mp.sv
// Directed vector table plus randomized run against an array-based model of regbank_mp.
// REGBANK_BYPASS_EN selects the write-first expectations.
module tb_regbank_mp;
    import regbank_pkg::*;

    localparam int NRD  = 4;
    localparam int NREG = 16;
    localparam logic [31:0] PC_RST = 32'hBFC0_0000;
`ifdef REGBANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic                  rstN;
        logic                  re;
        logic [NRD-1:0][3:0]   ra;
        logic                  we;
        reg_addr_t             wa;
        word_t                 wd;
        logic                  iv;
        reg_addr_t             ia;
        logic                  pcWe;
        word_t                 pcIn;
        logic [NRD-1:0]        expHaz;
        logic [NRD-1:0][31:0]  expRd;
        logic [NREG-1:0]       expBusy;
        word_t                 expPc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   nChecks = 0;
    int   nBad    = 0;

    always #5 clk = ~clk;

    regbank_mp_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(NRD)) bus ();

    regbank_mp #(
        .DATA_W   (32),
        .ADDR_W   (4),
        .NUM_RD   (NRD),
        .PC_RESET (PC_RST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t blank();
        vec_t v;
        v.rstN = 1'b1; v.re = 1'b0; v.ra = '0; v.we = 1'b0; v.wa = '0; v.wd = '0;
        v.iv = 1'b0; v.ia = '0; v.pcWe = 1'b0; v.pcIn = '0;
        v.expHaz = '0; v.expRd = '0; v.expBusy = '0; v.expPc = PC_RST;
        return v;
    endfunction

    function automatic logic [NRD-1:0][3:0] ra4(input int a0, input int a1, input int a2, input int a3);
        logic [NRD-1:0][3:0] r;
        r[0] = 4'(a0); r[1] = 4'(a1); r[2] = 4'(a2); r[3] = 4'(a3);
        return r;
    endfunction

    function automatic logic [NRD-1:0][31:0] rd4(input word_t d0, input word_t d1, input word_t d2, input word_t d3);
        logic [NRD-1:0][31:0] r;
        r[0] = d0; r[1] = d1; r[2] = d2; r[3] = d3;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst_n          = v.rstN;
        bus.re         = v.re;
        bus.rd_addr    = v.ra;
        bus.we         = v.we;
        bus.wr_addr    = v.wa;
        bus.wr_data    = v.wd;
        bus.issue_vld  = v.iv;
        bus.issue_addr = v.ia;
        bus.pc_we      = v.pcWe;
        bus.pc_in      = v.pcIn;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s step=%0d got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    vec_t vecs[20];

    // Reference model state for the randomized phase.
    word_t          mRegs [NREG];
    bit             mBusy [NREG];
    word_t          mRd   [NRD];
    word_t          mPc;

    initial begin
        vec_t v;
        word_t oldCollide;

        v = blank(); v.rstN = 1'b0;                                        vecs[0] = v;
        v = blank(); v.re = 1; v.ra = ra4(1, 2, 3, 4);                     vecs[1] = v;
        v = blank(); v.we = 1; v.wa = 5; v.wd = 32'hDEAD_BEEF;             vecs[2] = v;
        v = blank(); v.re = 1; v.ra = ra4(5, 5, 0, 15);
        v.expRd = rd4(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);                 vecs[3] = v;
        v = blank(); v.re = 1; v.ra = ra4(5, 3, 0, 15); v.we = 1; v.wa = 3; v.wd = 32'h1234;
        v.expRd = rd4(32'hDEAD_BEEF, BYP ? 32'h1234 : 32'h0, 0, 0);        vecs[4] = v;
        v = blank(); v.re = 1; v.ra = ra4(5, 3, 0, 15);
        v.expRd = rd4(32'hDEAD_BEEF, 32'h1234, 0, 0);                      vecs[5] = v;
        v = blank(); v.iv = 1; v.ia = 7;
        v.expRd = rd4(32'hDEAD_BEEF, 32'h1234, 0, 0); v.expBusy = 16'h0080; vecs[6] = v;
        v = blank(); v.re = 1; v.ra = ra4(0, 0, 7, 0); v.expHaz = 4'b0100;
        v.expBusy = 16'h0080;                                              vecs[7] = v;
        v = blank(); v.re = 1; v.ra = ra4(0, 0, 7, 0); v.we = 1; v.wa = 7; v.wd = 32'h77;
        v.expHaz = BYP ? 4'b0000 : 4'b0100;
        v.expRd = rd4(0, 0, BYP ? 32'h77 : 32'h0, 0);                      vecs[8] = v;
        v = blank(); v.re = 1; v.ra = ra4(0, 0, 7, 0);
        v.expRd = rd4(0, 0, 32'h77, 0);                                    vecs[9] = v;
        v = blank(); v.iv = 1; v.ia = 9; v.we = 1; v.wa = 9; v.wd = 32'h99;
        v.expRd = rd4(0, 0, 32'h77, 0); v.expBusy = 16'h0200;              vecs[10] = v;
        v = blank(); v.iv = 1; v.ia = 2;
        v.expRd = rd4(0, 0, 32'h77, 0); v.expBusy = 16'h0204;              vecs[11] = v;
        v = blank(); v.iv = 1; v.ia = 1; v.we = 1; v.wa = 2; v.wd = 32'h22;
        v.re = 1; v.ra = ra4(1, 2, 9, 3); v.expHaz = BYP ? 4'b0100 : 4'b0110;
        v.expRd = rd4(0, BYP ? 32'h22 : 32'h0, 32'h99, 32'h1234);
        v.expBusy = 16'h0202;                                              vecs[12] = v;
        // Re-issue to a busy register keeps the hazard visible even with bypass.
        oldCollide = BYP ? 32'h100 : 32'h99;
        v = blank(); v.iv = 1; v.ia = 9; v.we = 1; v.wa = 9; v.wd = 32'h100;
        v.re = 1; v.ra = ra4(9, 9, 9, 9); v.expHaz = 4'b1111;
        v.expRd = rd4(oldCollide, oldCollide, oldCollide, oldCollide);
        v.expBusy = 16'h0202;                                              vecs[13] = v;
        v = blank(); v.pcWe = 1; v.pcIn = 32'h40;
        v.expRd = rd4(oldCollide, oldCollide, oldCollide, oldCollide);
        v.expBusy = 16'h0202; v.expPc = 32'h40;                            vecs[14] = v;
        for (int k = 15; k < 18; k++) begin
            v = blank();
            v.expRd = rd4(oldCollide, oldCollide, oldCollide, oldCollide);
            v.expBusy = 16'h0202; v.expPc = 32'h40;                        vecs[k] = v;
        end
        v = blank(); v.rstN = 1'b0; v.pcWe = 1; v.pcIn = 32'h80; v.we = 1; v.wa = 5;
        v.wd = 32'h55; v.iv = 1; v.ia = 4; v.re = 1; v.ra = ra4(1, 0, 0, 0);
        v.expHaz = 4'b0001;                                                vecs[18] = v;
        v = blank(); v.re = 1; v.ra = ra4(5, 3, 7, 9);                     vecs[19] = v;

        for (int k = 0; k < 20; k++) begin
            applyStimulus(vecs[k]);
            #1;
            checkOutput("hazard", k, 128'(bus.hazard), 128'(vecs[k].expHaz));
            @(posedge clk);
            @(negedge clk);
            checkOutput("rd_data", k, 128'(bus.rd_data), 128'(vecs[k].expRd));
            checkOutput("busy", k, 128'(bus.busy), 128'(vecs[k].expBusy));
            checkOutput("pc_out", k, 128'(bus.pc_out), 128'(vecs[k].expPc));
        end

        for (int n = 0; n < 500; n++) begin
            logic [NRD-1:0]  expHaz;
            logic [NRD*32-1:0] expRd;
            logic [NREG-1:0] expBusy;

            v = blank();
            v.rstN = (n == 0 || $urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            v.re   = ($urandom_range(0, 3) != 0);
            v.we   = $urandom_range(0, 1) == 1;
            v.wa   = 4'($urandom_range(0, 15));
            v.wd   = $urandom;
            v.iv   = ($urandom_range(0, 4) < 2);
            v.ia   = ($urandom_range(0, 3) == 0) ? v.wa : 4'($urandom_range(0, 15));
            v.pcWe = ($urandom_range(0, 3) == 0);
            v.pcIn = $urandom;
            for (int i = 0; i < NRD; i++)
                v.ra[i] = ($urandom_range(0, 2) == 0) ? v.wa : 4'($urandom_range(0, 15));

            applyStimulus(v);
            #1;
            for (int i = 0; i < NRD; i++)
                expHaz[i] = v.re && mBusy[v.ra[i]]
                          && !(BYP && v.we && v.wa == v.ra[i] && !(v.iv && v.ia == v.ra[i]));
            checkOutput("rand_hazard", n, 128'(bus.hazard), 128'(expHaz));

            @(posedge clk);
            if (!v.rstN) begin
                for (int r = 0; r < NREG; r++) begin mRegs[r] = '0; mBusy[r] = 1'b0; end
                for (int i = 0; i < NRD; i++) mRd[i] = '0;
                mPc = PC_RST;
            end else begin
                if (v.re)
                    for (int i = 0; i < NRD; i++)
                        mRd[i] = (BYP && v.we && v.wa == v.ra[i]) ? v.wd : mRegs[v.ra[i]];
                if (v.we) begin mRegs[v.wa] = v.wd; mBusy[v.wa] = 1'b0; end
                if (v.iv) mBusy[v.ia] = 1'b1;
                if (v.pcWe) mPc = v.pcIn;
            end
            @(negedge clk);

            for (int i = 0; i < NRD; i++) expRd[i*32 +: 32] = mRd[i];
            for (int r = 0; r < NREG; r++) expBusy[r] = mBusy[r];
            checkOutput("rand_rd_data", n, 128'(bus.rd_data), 128'(expRd));
            checkOutput("rand_busy", n, 128'(bus.busy), 128'(expBusy));
            checkOutput("rand_pc_out", n, 128'(bus.pc_out), 128'(mPc));
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
